logic_issue_stage: RTL and testbench

- Decode-and-issue stage that produces the operand/op interface consumed by the EX-stage logic ALU: aluEnable, op, srcl, srcr, plus writeback tags.
- Decodes MIPS logical instructions (AND, OR, XOR, NOR, ANDI, ORI, XORI, LUI).
- Reads the register file, resolves operands through EX/MEM forwarding, detects load-use hazards.
- Registers the result into the ID/EX pipeline register with stall, flush and bubble control.

---
 rtl/logic_issue_stage.sv | 214 +++++++++++++++++++++
 tb/tb_logic_issue_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_issue_stage.sv
// logic_issue_stage: decodes MIPS logical instructions, resolves operands via
// EX/MEM forwarding, detects load-use hazards and registers the ID/EX bundle
// consumed by the EX-stage logic ALU.
module logic_issue_stage #(
    parameter int          OP_W        = 8,
    parameter logic [3:0]  LOGIC_CLASS = 4'b0001,
    parameter int          REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [31:0]       ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [31:0]       mem_wdata,
    output logic              stall_req,
    output logic              illegal,
    output logic              aluEnable,
    output logic [OP_W-1:0]   op,
    output logic [31:0]       srcl,
    output logic [31:0]       srcr,
    output logic              wen,
    output logic [REG_AW-1:0] waddr
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_LUI = 4'd4;

    // Register 0 is hard-wired to zero and never forwarded; EX beats MEM.
    function automatic logic [31:0] resolve_operand(
        input logic [REG_AW-1:0] r,
        input logic [31:0]       rf_data,
        input logic              exw,
        input logic [REG_AW-1:0] exa,
        input logic [31:0]       exd,
        input logic              memw,
        input logic [REG_AW-1:0] mema,
        input logic [31:0]       memd
    );
        logic [31:0] v;
        if (r == {REG_AW{1'b0}}) begin
            v = 32'd0;
        end else if (exw && (exa == r)) begin
            v = exd;
        end else if (memw && (mema == r)) begin
            v = memd;
        end else begin
            v = rf_data;
        end
        return v;
    endfunction

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic [REG_AW-1:0] rd_s;
    logic [15:0]       imm_s;

    logic              legal_s;
    logic              use_rs_s;
    logic              use_rt_s;
    logic              imm_sel_s;
    logic [3:0]        code_s;
    logic [REG_AW-1:0] dest_s;
    logic [31:0]       srcl_s;
    logic [31:0]       srcr_s;
    logic              hazard_s;

    logic              alu_en_r;
    logic [OP_W-1:0]   op_r;
    logic [31:0]       srcl_r;
    logic [31:0]       srcr_r;
    logic              wen_r;
    logic [REG_AW-1:0] waddr_r;
    logic              illegal_r;

    assign opcode_s = inst[31:26];
    assign rs_s     = inst[25:21];
    assign rt_s     = inst[20:16];
    assign rd_s     = inst[15:11];
    assign funct_s  = inst[5:0];
    assign imm_s    = inst[15:0];

    // Register-file addresses come straight from the rs/rt fields.
    assign rf_raddr1 = rs_s;
    assign rf_raddr2 = rt_s;

    // Instruction decode: legality, concrete op, used sources and destination.
    always_comb begin
        legal_s   = 1'b0;
        use_rs_s  = 1'b0;
        use_rt_s  = 1'b0;
        imm_sel_s = 1'b0;
        code_s    = OP_AND;
        dest_s    = {REG_AW{1'b0}};
        case (opcode_s)
            6'h00: begin
                case (funct_s)
                    6'h24: begin legal_s = 1'b1; code_s = OP_AND; end
                    6'h25: begin legal_s = 1'b1; code_s = OP_OR;  end
                    6'h26: begin legal_s = 1'b1; code_s = OP_XOR; end
                    6'h27: begin legal_s = 1'b1; code_s = OP_NOR; end
                    default: begin legal_s = 1'b0; code_s = OP_AND; end
                endcase
                use_rs_s = legal_s;
                use_rt_s = legal_s;
                dest_s   = rd_s;
            end
            6'h0C: begin legal_s = 1'b1; code_s = OP_AND; use_rs_s = 1'b1; imm_sel_s = 1'b1; dest_s = rt_s; end
            6'h0D: begin legal_s = 1'b1; code_s = OP_OR;  use_rs_s = 1'b1; imm_sel_s = 1'b1; dest_s = rt_s; end
            6'h0E: begin legal_s = 1'b1; code_s = OP_XOR; use_rs_s = 1'b1; imm_sel_s = 1'b1; dest_s = rt_s; end
            6'h0F: begin legal_s = 1'b1; code_s = OP_LUI; imm_sel_s = 1'b1; dest_s = rt_s; end
            default: begin
                legal_s   = 1'b0;
                imm_sel_s = 1'b0;
            end
        endcase
    end

    // Operand selection; unused sources read as zero.
    always_comb begin
        srcl_s = 32'd0;
        srcr_s = 32'd0;
        if (use_rs_s) begin
            srcl_s = resolve_operand(rs_s, rf_rdata1, ex_wen, ex_waddr, ex_wdata,
                                     mem_wen, mem_waddr, mem_wdata);
        end else begin
            srcl_s = 32'd0;
        end
        if (imm_sel_s) begin
            srcr_s = {16'd0, imm_s};
        end else if (use_rt_s) begin
            srcr_s = resolve_operand(rt_s, rf_rdata2, ex_wen, ex_waddr, ex_wdata,
                                     mem_wen, mem_waddr, mem_wdata);
        end else begin
            srcr_s = 32'd0;
        end
    end

    // Load-use hazard: an in-flight load targets a source this instruction reads.
    always_comb begin
        hazard_s = 1'b0;
        if (inst_valid && ex_is_load && ex_wen && (ex_waddr != {REG_AW{1'b0}})) begin
            hazard_s = (use_rs_s && (ex_waddr == rs_s)) ||
                       (use_rt_s && (ex_waddr == rt_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign stall_req = hazard_s;

    // ID/EX register: flush beats stall, stall holds, otherwise bubble or issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_en_r  <= 1'b0;
            op_r      <= {OP_W{1'b0}};
            srcl_r    <= 32'd0;
            srcr_r    <= 32'd0;
            wen_r     <= 1'b0;
            waddr_r   <= {REG_AW{1'b0}};
            illegal_r <= 1'b0;
        end else if (flush_i) begin
            alu_en_r  <= 1'b0;
            op_r      <= {OP_W{1'b0}};
            srcl_r    <= 32'd0;
            srcr_r    <= 32'd0;
            wen_r     <= 1'b0;
            waddr_r   <= {REG_AW{1'b0}};
            illegal_r <= 1'b0;
        end else if (stall_i) begin
            illegal_r <= 1'b0;
        end else if (hazard_s || !inst_valid || !legal_s) begin
            alu_en_r  <= 1'b0;
            op_r      <= {OP_W{1'b0}};
            srcl_r    <= 32'd0;
            srcr_r    <= 32'd0;
            wen_r     <= 1'b0;
            waddr_r   <= {REG_AW{1'b0}};
            illegal_r <= inst_valid && !legal_s;
        end else begin
            alu_en_r  <= 1'b1;
            op_r      <= OP_W'({LOGIC_CLASS, code_s});
            srcl_r    <= srcl_s;
            srcr_r    <= srcr_s;
            wen_r     <= 1'b1;
            waddr_r   <= dest_s;
            illegal_r <= 1'b0;
        end
    end

    assign aluEnable = alu_en_r;
    assign op        = op_r;
    assign srcl      = srcl_r;
    assign srcr      = srcr_r;
    assign wen       = wen_r;
    assign waddr     = waddr_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_logic_issue_stage.sv
// Testbench for logic_issue_stage: directed cases plus randomized stimulus
// checked against a field-level reference model of the issue stage.
module tb_logic_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic        stall_i, flush_i;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_wen;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_is_load;
    logic        mem_wen;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        stall_req, illegal, aluEnable, wen;
    logic [7:0]  op;
    logic [31:0] srcl, srcr;
    logic [4:0]  waddr;

    logic [31:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    // expected ID/EX state
    logic        e_alu, e_wen, e_ill;
    logic [7:0]  e_op;
    logic [31:0] e_srcl, e_srcr;
    logic [4:0]  e_waddr;

    logic_issue_stage dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
        .stall_i(stall_i), .flush_i(flush_i),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_req(stall_req), .illegal(illegal), .aluEnable(aluEnable),
        .op(op), .srcl(srcl), .srcr(srcr), .wen(wen), .waddr(waddr)
    );

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (ex_wen && ex_waddr == r) return ex_wdata;
        if (mem_wen && mem_waddr == r) return mem_wdata;
        return rf[r];
    endfunction

    task automatic model_bubble();
        e_alu = 1'b0; e_op = 8'h00; e_srcl = 32'd0; e_srcr = 32'd0; e_wen = 1'b0; e_waddr = 5'd0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_aluEnable"}, {31'd0, aluEnable}, {31'd0, e_alu});
        check({pfx, "_op"}, {24'd0, op}, {24'd0, e_op});
        check({pfx, "_srcl"}, srcl, e_srcl);
        check({pfx, "_srcr"}, srcr, e_srcr);
        check({pfx, "_wen"}, {31'd0, wen}, {31'd0, e_wen});
        check({pfx, "_waddr"}, {27'd0, waddr}, {27'd0, e_waddr});
        check({pfx, "_illegal"}, {31'd0, illegal}, {31'd0, e_ill});
    endtask

    // Inputs are set just after a negedge; checks comb outputs, clocks once,
    // checks registered outputs, and returns at the following negedge.
    task automatic step(input string tag);
        logic [5:0]  opc, fn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic        legal, use_rs, use_rt, hz;
        int          code;
        logic [31:0] l, r;
        logic [4:0]  d;
        opc = inst[31:26]; fn = inst[5:0];
        rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11]; imm = inst[15:0];
        legal = 1'b0; use_rs = 1'b0; use_rt = 1'b0; code = 0; l = 32'd0; r = 32'd0; d = 5'd0;
        if (opc == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
            legal = 1'b1; code = int'(fn) - 36; use_rs = 1'b1; use_rt = 1'b1;
            l = fwd(rs); r = fwd(rt); d = rd;
        end else if (opc >= 6'h0C && opc <= 6'h0E) begin
            legal = 1'b1; code = int'(opc) - 12; use_rs = 1'b1;
            l = fwd(rs); r = {16'd0, imm}; d = rt;
        end else if (opc == 6'h0F) begin
            legal = 1'b1; code = 4; l = 32'd0; r = {16'd0, imm}; d = rt;
        end
        hz = inst_valid && ex_is_load && ex_wen && ex_waddr != 5'd0 &&
             ((use_rs && ex_waddr == rs) || (use_rt && ex_waddr == rt));
        #1;
        check({tag, "_stall_req"}, {31'd0, stall_req}, {31'd0, hz});
        check({tag, "_raddr1"}, {27'd0, rf_raddr1}, {27'd0, rs});
        check({tag, "_raddr2"}, {27'd0, rf_raddr2}, {27'd0, rt});
        @(posedge clk);
        if (flush_i) begin
            model_bubble(); e_ill = 1'b0;
        end else if (stall_i) begin
            e_ill = 1'b0;
        end else if (hz || !inst_valid || !legal) begin
            model_bubble(); e_ill = inst_valid && !legal;
        end else begin
            e_alu = 1'b1; e_op = 8'h10 + 8'(code); e_srcl = l; e_srcr = r;
            e_wen = 1'b1; e_waddr = d; e_ill = 1'b0;
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic quiet();
        inst_valid = 1'b0; inst = 32'd0; stall_i = 1'b0; flush_i = 1'b0;
        ex_wen = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_is_load = 1'b0;
        mem_wen = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0;
    endtask

    // Asynchronous reset raised mid-cycle; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_bubble(); e_ill = 1'b0;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'd0;
        quiet();
        rst = 1'b1;
        model_bubble(); e_ill = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // ORI $3,$1,0xF0F0
        rf[1] = 32'h12340000;
        inst_valid = 1'b1; inst = itype(6'h0D, 5'd1, 5'd3, 16'hF0F0);
        step("ori");
        check("ori_op_const", {24'd0, op}, 32'h11);
        check("ori_srcl_const", srcl, 32'h12340000);
        check("ori_srcr_const", srcr, 32'h0000F0F0);
        check("ori_waddr_const", {27'd0, waddr}, 32'd3);

        // reset while aluEnable=1
        check("pre_rst_alu", {31'd0, aluEnable}, 32'd1);
        async_reset("rst_live");

        // NOR $5,$2,$4: EX and MEM both hit $2, EX wins
        inst = rtype(6'h27, 5'd2, 5'd4, 5'd5);
        ex_wen = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'hAAAA0000;
        mem_wen = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h00005555;
        step("nor_exwins");
        check("nor_srcl_const", srcl, 32'hAAAA0000);
        mem_waddr = 5'd4;
        step("nor_memfwd");
        check("nor_srcr_const", srcr, 32'h00005555);
        check("nor_op_const", {24'd0, op}, 32'h13);

        // AND $6,$0,$7 with EX targeting $0
        ex_waddr = 5'd0; ex_wdata = 32'hFFFFFFFF; mem_wen = 1'b0;
        inst = rtype(6'h24, 5'd0, 5'd7, 5'd6);
        step("and_r0");
        check("and_r0_srcl_const", srcl, 32'd0);

        // load-use on rs, then release
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h0;
        inst = itype(6'h0E, 5'd1, 5'd2, 16'h0001);
        step("xori_hz");
        check("xori_hz_bubble", {31'd0, aluEnable}, 32'd0);
        ex_is_load = 1'b0; ex_wdata = 32'h0BAD0001;
        step("xori_go");
        check("xori_go_srcl", srcl, 32'h0BAD0001);

        // load into an unused source: no stall
        ex_is_load = 1'b1; ex_waddr = 5'd2;
        inst = itype(6'h0F, 5'd0, 5'd2, 16'hBEEF);
        step("lui_nohz");
        check("lui_op_const", {24'd0, op}, 32'h14);
        check("lui_srcr_const", srcr, 32'h0000BEEF);
        ex_is_load = 1'b0; ex_wen = 1'b0;

        // flush beats stall
        flush_i = 1'b1; stall_i = 1'b1;
        step("flush_stall");
        flush_i = 1'b0; stall_i = 1'b0;
        inst = rtype(6'h25, 5'd8, 5'd9, 5'd10);
        step("or_issue");

        // stall holds for 3 cycles while input changes
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst = rtype(6'h26, 5'($urandom_range(1, 31)), 5'd3, 5'd4);
            step("stall_hold");
        end
        check("stall_hold_waddr", {27'd0, waddr}, 32'd10);
        stall_i = 1'b0;

        // illegal funct, then pulse ends
        inst = rtype(6'h3F, 5'd1, 5'd2, 5'd3);
        step("illegal");
        check("illegal_pulse", {31'd0, illegal}, 32'd1);
        inst_valid = 1'b0;
        step("illegal_end");

        // reset during stall
        inst_valid = 1'b1; inst = itype(6'h0C, 5'd5, 5'd6, 16'h1234);
        step("andi");
        stall_i = 1'b1;
        step("andi_stall");
        async_reset("rst_stall");
        stall_i = 1'b0;
        inst_valid = 1'b0;
        step("post_rst");

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int k;
            logic [4:0] a, b, c;
            a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 31));
            k = $urandom_range(0, 9);
            if (k < 4)       inst = rtype(6'(36 + k), a, b, c);
            else if (k < 8)  inst = itype(6'(8 + k), a, b, 16'($urandom));
            else if (k == 8) inst = rtype(6'($urandom), a, b, c);
            else             inst = $urandom;
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 7)] = $urandom;
            inst_valid = ($urandom_range(0, 9) != 0);
            flush_i    = ($urandom_range(0, 9) == 0);
            stall_i    = ($urandom_range(0, 6) == 0);
            ex_wen     = $urandom_range(0, 1) == 1;
            ex_waddr   = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_is_load = ($urandom_range(0, 3) == 0);
            mem_wen    = $urandom_range(0, 1) == 1;
            mem_waddr  = 5'($urandom_range(0, 7));
            mem_wdata  = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
